alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer_pkg.sv | 28 ++
 rtl/cond_eval.sv | 44 ++++
 rtl/alu_result_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_result_buffer_pkg.sv
// Shared ALU definitions: NZCV flag bit positions and condition-code encodings.
package alu_result_buffer_pkg;

   localparam int unsigned flag_n = 3;
   localparam int unsigned flag_z = 2;
   localparam int unsigned flag_c = 1;
   localparam int unsigned flag_v = 0;

   typedef enum logic [3:0] {
      cc_eq = 4'd0,
      cc_ne = 4'd1,
      cc_cs = 4'd2,
      cc_cc = 4'd3,
      cc_mi = 4'd4,
      cc_pl = 4'd5,
      cc_vs = 4'd6,
      cc_vc = 4'd7,
      cc_hi = 4'd8,
      cc_ls = 4'd9,
      cc_ge = 4'd10,
      cc_lt = 4'd11,
      cc_gt = 4'd12,
      cc_le = 4'd13,
      cc_al = 4'd14,
      cc_nv = 4'd15
   } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: tests a 4-bit condition against the NZCV status register.
module cond_eval
   import alu_result_buffer_pkg::*;
(
   input  logic [3:0] status,
   input  logic [3:0] cond,
   output logic       cond_true
);

   logic n_s, z_s, c_s, v_s;
   logic cond_true_s;

   assign n_s = status[flag_n];
   assign z_s = status[flag_z];
   assign c_s = status[flag_c];
   assign v_s = status[flag_v];

   // Decode the condition against the current flags.
   always_comb begin
      cond_true_s = 1'b0;
      case (cond_e'(cond))
         cc_eq:   cond_true_s = z_s;
         cc_ne:   cond_true_s = !z_s;
         cc_cs:   cond_true_s = c_s;
         cc_cc:   cond_true_s = !c_s;
         cc_mi:   cond_true_s = n_s;
         cc_pl:   cond_true_s = !n_s;
         cc_vs:   cond_true_s = v_s;
         cc_vc:   cond_true_s = !v_s;
         cc_hi:   cond_true_s = c_s && !z_s;
         cc_ls:   cond_true_s = !c_s || z_s;
         cc_ge:   cond_true_s = (n_s == v_s);
         cc_lt:   cond_true_s = (n_s != v_s);
         cc_gt:   cond_true_s = !z_s && (n_s == v_s);
         cc_le:   cond_true_s = z_s || (n_s != v_s);
         cc_al:   cond_true_s = 1'b1;
         cc_nv:   cond_true_s = 1'b0;
         default: cond_true_s = 1'b0;
      endcase
   end

   assign cond_true = cond_true_s;

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry in-order buffer for ALU results/flags with an NZCV status register
// and condition evaluation against that register.
module alu_result_buffer
   import alu_result_buffer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_zero,
   input  logic             in_overflow,
   input  logic             in_carryOut,
   input  logic             in_negative,
   input  logic             in_setflags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic [3:0]       status,
   input  logic [3:0]       cond,
   output logic             cond_true,
   output logic [1:0]       count
);

   localparam logic [1:0] depth_c = 2'(DEPTH);

   logic [WIDTH-1:0] mem_result_r [DEPTH];
   logic [3:0]       mem_flags_r  [DEPTH];
   logic             wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
   logic [1:0]       count_r, count_next_s;
   logic [3:0]       status_r, in_flags_s, head_flags_s, out_flags_r;
   logic [WIDTH-1:0] head_result_s, out_result_r;
   logic             push_s, pop_s;

   assign in_ready  = (count_r < depth_c);
   assign out_valid = (count_r != 2'd0);
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   // Pack incoming flags into NZCV order.
   always_comb begin
      in_flags_s         = 4'b0000;
      in_flags_s[flag_n] = in_negative;
      in_flags_s[flag_z] = in_zero;
      in_flags_s[flag_c] = in_carryOut;
      in_flags_s[flag_v] = in_overflow;
   end

   // Next head: the entry being written bypasses storage when it lands in the head slot.
   always_comb begin
      if (pop_s) begin
         rd_ptr_next_s = rd_ptr_r + 1'b1;
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_result_s = in_result;
         head_flags_s  = in_flags_s;
      end else begin
         head_result_s = mem_result_r[rd_ptr_next_s];
         head_flags_s  = mem_flags_r[rd_ptr_next_s];
      end
   end

   // Occupancy update.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + 2'd1;
         2'b01:   count_next_s = count_r - 2'd1;
         default: count_next_s = count_r;
      endcase
   end

   // Storage, pointers, status and registered head outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_result_r[i] <= '0;
            mem_flags_r[i]  <= 4'b0000;
         end
         wr_ptr_r     <= 1'b0;
         rd_ptr_r     <= 1'b0;
         count_r      <= 2'd0;
         status_r     <= 4'b0000;
         out_result_r <= '0;
         out_flags_r  <= 4'b0000;
      end else begin
         if (push_s) begin
            mem_result_r[wr_ptr_r] <= in_result;
            mem_flags_r[wr_ptr_r]  <= in_flags_s;
            wr_ptr_r               <= wr_ptr_r + 1'b1;
            if (in_setflags) begin
               status_r <= in_flags_s;
            end
         end
         rd_ptr_r     <= rd_ptr_next_s;
         count_r      <= count_next_s;
         out_result_r <= head_result_s;
         out_flags_r  <= head_flags_s;
      end
   end

   cond_eval u_cond_eval (
      .status    (status_r),
      .cond      (cond),
      .cond_true (cond_true)
   );

   assign out_result = out_result_r;
   assign out_flags  = out_flags_r;
   assign status     = status_r;
   assign count      = count_r;

endmodule
